// File: rtl/ex_muldiv_if.sv
// Execute-stage bundle between id_ex, the iterative mul/div unit and writeback.
// Signal suffixes follow the unit's own point of view.
interface ex_muldiv_if;
   logic [31:0] inst_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic [4:0]  rd_addr_i;
   logic        reg_wen_i;
   logic        hold_flag_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic        reg_wen_o;

   modport slave (
      input  inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
      output hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o
   );

   modport master (
      output inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
      input  hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o
   );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per cycle
// on operand magnitudes, sign fix on the final step, one registered writeback pulse.
module ex_muldiv #(
   parameter int unsigned DW    = 32,
   parameter int unsigned ITERS = 32
) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   localparam logic [6:0] OpReg   = 7'b0110011;
   localparam logic [6:0] F7Mul   = 7'b0000001;
   localparam logic [5:0] LastCnt = 6'(ITERS - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
   function automatic logic sgn_a(input logic [2:0] f3);
      return (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
   endfunction

   function automatic logic sgn_b(input logic [2:0] f3);
      return (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
   endfunction

   state_e          state_q, state_d;
   logic [5:0]      cnt_q, cnt_d;
   logic [DW-1:0]   op1_q, op1_d, op2_q, op2_d, dvs_q, dvs_d;
   logic [2*DW-1:0] acc_q, acc_d;
   logic [2:0]      f3_q, f3_d;
   logic [4:0]      rd_q, rd_d;
   logic            wen_q, wen_d;
   logic [DW-1:0]   wb_data_q, wb_data_d;
   logic [4:0]      wb_addr_q, wb_addr_d;
   logic            wb_wen_q, wb_wen_d;

   logic            is_m;
   logic [2:0]      in_f3;
   logic [DW-1:0]   abs_a, abs_b;
   logic            unused_inst;

   assign is_m  = (bus.inst_i[6:0] == OpReg) && (bus.inst_i[31:25] == F7Mul);
   assign in_f3 = bus.inst_i[14:12];
   assign abs_a = (sgn_a(in_f3) && bus.op1_i[DW-1]) ? -bus.op1_i : bus.op1_i;
   assign abs_b = (sgn_b(in_f3) && bus.op2_i[DW-1]) ? -bus.op2_i : bus.op2_i;
   assign unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

   // Mul: acc = {partial, multiplier}; div: acc = {remainder, dividend/quotient}
   logic [DW:0]     mul_sum, div_rs;
   logic [DW+1:0]   div_diff;
   logic [2*DW-1:0] step, prod;
   logic            mul_neg, q_neg, r_neg;
   logic [DW-1:0]   quo, rem, result;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
      div_rs   = acc_q[2*DW-1:DW-1];
      div_diff = {1'b0, div_rs} - {2'b00, dvs_q};
      if (f3_q[2]) begin
         step = div_diff[DW+1] ? {div_rs[DW-1:0], acc_q[DW-2:0], 1'b0}
                               : {div_diff[DW-1:0], acc_q[DW-2:0], 1'b1};
      end else begin
         step = {mul_sum, acc_q[DW-1:1]};
      end
   end

   // Sign fix and special cases, evaluated on the last step's value
   always_comb begin
      mul_neg = (sgn_a(f3_q) & op1_q[DW-1]) ^ (sgn_b(f3_q) & op2_q[DW-1]);
      q_neg   = sgn_b(f3_q) & (op1_q[DW-1] ^ op2_q[DW-1]);
      r_neg   = sgn_a(f3_q) & op1_q[DW-1];
      prod    = mul_neg ? -step : step;
      quo     = q_neg ? -step[DW-1:0] : step[DW-1:0];
      rem     = r_neg ? -step[2*DW-1:DW] : step[2*DW-1:DW];
      case (f3_q)
         3'd0:             result = prod[DW-1:0];
         3'd1, 3'd2, 3'd3: result = prod[2*DW-1:DW];
         3'd4, 3'd5:       result = (op2_q == '0) ? '1 : quo;
         default:          result = (op2_q == '0) ? op1_q : rem;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      dvs_d     = dvs_q;
      acc_d     = acc_q;
      f3_d      = f3_q;
      rd_d      = rd_q;
      wen_d     = wen_q;
      wb_data_d = '0;
      wb_addr_d = '0;
      wb_wen_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (is_m) begin
               op1_d   = bus.op1_i;
               op2_d   = bus.op2_i;
               dvs_d   = abs_b;
               acc_d   = {{DW{1'b0}}, abs_a};
               f3_d    = in_f3;
               rd_d    = bus.rd_addr_i;
               wen_d   = bus.reg_wen_i;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LastCnt) begin
               state_d   = StDone;
               wb_data_d = result;
               wb_addr_d = rd_q;
               wb_wen_d  = wen_q;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         op1_q     <= '0;
         op2_q     <= '0;
         dvs_q     <= '0;
         acc_q     <= '0;
         f3_q      <= '0;
         rd_q      <= '0;
         wen_q     <= 1'b0;
         wb_data_q <= '0;
         wb_addr_q <= '0;
         wb_wen_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         dvs_q     <= dvs_d;
         acc_q     <= acc_d;
         f3_q      <= f3_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         wb_data_q <= wb_data_d;
         wb_addr_q <= wb_addr_d;
         wb_wen_q  <= wb_wen_d;
      end
   end

   assign bus.hold_flag_o = ((state_q == StIdle) && is_m) || (state_q == StCalc);
   assign bus.rd_addr_o   = wb_addr_q;
   assign bus.rd_data_o   = wb_data_q;
   assign bus.reg_wen_o   = wb_wen_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: vector table through a hold-respecting id_ex driver, scoreboard of
// expected writebacks checked on the writeback strobe, plus reset and back-to-back sequences.
module tb_ex_muldiv;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_muldiv_if bus ();

   ex_muldiv #(.DW(32), .ITERS(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [31:0] Nop = 32'h0000_0013;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          due;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
      return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   // Writeback monitor: every strobe must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.reg_wen_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_write: got write rd=%0d data=%h, expected none", bus.rd_addr_o,
                     bus.rd_data_o);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("wb_data", bus.rd_data_o, e.data);
            check("wb_addr", {27'd0, bus.rd_addr_o}, {27'd0, e.rd});
            check("wb_cycle", cyc, e.due);
         end
      end
   end

   // Presents one M-op like id_ex would, then feeds NOPs with junk operands while held.
   // Entered and left at a negedge; returns the acceptance cycle.
   task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic wen, input logic [31:0] exp,
                           output int t_acc);
      int tries = 0;
      int held  = 0;
      bus.inst_i    = mk_inst(f3, rd);
      bus.op1_i     = a;
      bus.op2_i     = b;
      bus.rd_addr_i = rd;
      bus.reg_wen_i = wen;
      #1;
      while (bus.hold_flag_o !== 1'b1 && tries < 3) begin
         @(negedge clk);
         #1;
         tries++;
      end
      if (bus.hold_flag_o !== 1'b1) begin
         check("accept_timeout", {31'd0, bus.hold_flag_o}, 32'd1);
         t_acc = -1;
         return;
      end
      t_acc = cyc;
      if (wen) sb.push_back('{rd: rd, data: exp, due: t_acc + 33});
      @(posedge clk);
      #1;
      bus.inst_i    = Nop;
      bus.op1_i     = $urandom;
      bus.op2_i     = $urandom;
      bus.rd_addr_i = 5'($urandom);
      @(negedge clk);
      while (bus.hold_flag_o === 1'b1 && held < 40) begin
         held++;
         bus.op1_i = $urandom;
         bus.op2_i = $urandom;
         @(negedge clk);
      end
      check("hold_cycles", held, 32);
   endtask

   vec_t vecs[18];
   int   t1, t2, t_rst;

   initial begin
      vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
      vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
      vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
      vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
      vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
      vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
      vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
      vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
      vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
      vecs[12] = '{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF};
      vecs[13] = '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9};
      vecs[14] = '{3'd0, 32'h1234_5678, 32'd9,         32'hA3D7_0A38};
      vecs[15] = '{3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
      vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
      vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1};

      rst           = 1'b1;
      bus.inst_i    = Nop;
      bus.op1_i     = '0;
      bus.op2_i     = '0;
      bus.rd_addr_i = '0;
      bus.reg_wen_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wen", {31'd0, bus.reg_wen_o}, 32'd0);
      check("rst_data", bus.rd_data_o, 32'd0);
      check("rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
      check("rst_hold_nop", {31'd0, bus.hold_flag_o}, 32'd0);
      bus.inst_i = mk_inst(3'd0, 5'd1);
      #1;
      check("rst_hold_minst", {31'd0, bus.hold_flag_o}, 32'd1);
      bus.inst_i = Nop;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         drive_op(vecs[i].f3, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, vecs[i].exp, t1);
      end

      // Write disabled: full latency, no strobe; then rd=0 with write enabled still strobes
      drive_op(3'd0, 32'd3, 32'd4, 5'd9, 1'b0, 32'd12, t1);
      drive_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b1, 32'd12, t1);

      // Back-to-back: next op sits on inst_i during DONE and is taken the cycle after
      drive_op(3'd5, 32'd1000, 32'd10, 5'd20, 1'b1, 32'd100, t1);
      drive_op(3'd0, 32'd6, 32'd7, 5'd21, 1'b1, 32'd42, t2);
      check("b2b_accept", t2, t1 + 34);

      // Reset ten cycles into a DIV abandons it without a write
      @(negedge clk);
      bus.inst_i    = mk_inst(3'd4, 5'd22);
      bus.op1_i     = 32'd77;
      bus.op2_i     = 32'd7;
      bus.rd_addr_i = 5'd22;
      bus.reg_wen_i = 1'b1;
      #1;
      t_rst = cyc;
      check("div_hold_accept", {31'd0, bus.hold_flag_o}, 32'd1);
      @(posedge clk);
      #1;
      bus.inst_i = Nop;
      repeat (10) @(negedge clk);
      check("rst_mid_cycle", cyc, t_rst + 10);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_hold", {31'd0, bus.hold_flag_o}, 32'd0);
      check("rst_mid_wen", {31'd0, bus.reg_wen_o}, 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("rst_mid_no_hold", {31'd0, bus.hold_flag_o}, 32'd0);

      drive_op(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd23, 1'b1, 32'd1, t1);
      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
